sobel_window_scheduler: RTL and testbench

Sequencing controller for the Sobel window datapath. It walks a frame of grayscale pixels in raster order, one 4-pixel group at a time, and requests each group from the grayscale unit with a req/ack handshake. It tells the 3x8 window buffer which slot to fill and when to shift, then issues one compute strobe per output pixel to the Sobel kernel and waits for each to complete. It sits between the top-level frame control (start / frame_done) and the grayscale, window-buffer and Sobel blocks.

---
 rtl/sobel_window_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_sobel_window_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_scheduler.sv
// sobel_window_scheduler
//   Walks a frame in raster order one 8-pixel window at a time. For each window it
//   fetches gray groups into the 3x8 window buffer, fires one Sobel compute strobe
//   per output pixel, and slides the window right by one group between windows.
//
// Ports
//   clk, n_rst                        clock, async active-low reset
//   start                             frame start pulse (IDLE only)
//   fetch_req/fetch_ack               gray-group request handshake
//   fetch_row/fetch_grp               address of the requested group
//   fill_line/fill_half               window slot the group lands in
//   shift_win                         window copies right half into left half
//   compute_start/compute_done        Sobel kernel strobe / completion
//   comp_pos/out_row/out_col          window offset and image position of the output
//   busy/frame_done                   frame status
//
// Every output is a flop loaded from the next-state view of the FSM, so nothing
// reaches an output combinationally from an input.
module sobel_window_scheduler #(
    parameter  int IMG_W = 16,
    parameter  int IMG_H = 4,
    localparam int G     = IMG_W / 4,
    localparam int ROW_W = $clog2(IMG_H),
    localparam int GRP_W = $clog2(G),
    localparam int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    output logic             fetch_req,
    output logic [ROW_W-1:0] fetch_row,
    output logic [GRP_W-1:0] fetch_grp,
    output logic [1:0]       fill_line,
    output logic             fill_half,
    input  logic             fetch_ack,
    output logic             shift_win,
    output logic             compute_start,
    output logic [1:0]       comp_pos,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    input  logic             compute_done,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SHIFT, S_COMPUTE, S_WAIT, S_DONE
    } state_t;

    localparam logic [GRP_W-1:0] G_LAST = GRP_W'(G - 2);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(IMG_H - 2);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [GRP_W-1:0] g_q, g_d;
    logic [2:0]       f_q, f_d;
    logic [1:0]       k_q, k_d;
    logic             full_q, full_d;

    // Slot index within the six-slot full-load order. A partial load is the
    // tail of that order (slots 3..5), so one decoder serves both load kinds.
    logic [2:0]       e_q, e_d;

    logic             fetch_req_q, fetch_req_d;
    logic [ROW_W-1:0] fetch_row_q, fetch_row_d;
    logic [GRP_W-1:0] fetch_grp_q, fetch_grp_d;
    logic [1:0]       fill_line_q, fill_line_d;
    logic             fill_half_q, fill_half_d;
    logic             shift_win_q, shift_win_d;
    logic             compute_start_q, compute_start_d;
    logic [1:0]       comp_pos_q, comp_pos_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    assign e_q = full_q ? f_q : f_q + 3'd3;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= S_IDLE;
            r_q             <= '0;
            g_q             <= '0;
            f_q             <= '0;
            k_q             <= '0;
            full_q          <= 1'b0;
            fetch_req_q     <= 1'b0;
            fetch_row_q     <= '0;
            fetch_grp_q     <= '0;
            fill_line_q     <= '0;
            fill_half_q     <= 1'b0;
            shift_win_q     <= 1'b0;
            compute_start_q <= 1'b0;
            comp_pos_q      <= '0;
            out_row_q       <= '0;
            out_col_q       <= '0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            r_q             <= r_d;
            g_q             <= g_d;
            f_q             <= f_d;
            k_q             <= k_d;
            full_q          <= full_d;
            fetch_req_q     <= fetch_req_d;
            fetch_row_q     <= fetch_row_d;
            fetch_grp_q     <= fetch_grp_d;
            fill_line_q     <= fill_line_d;
            fill_half_q     <= fill_half_d;
            shift_win_q     <= shift_win_d;
            compute_start_q <= compute_start_d;
            comp_pos_q      <= comp_pos_d;
            out_row_q       <= out_row_d;
            out_col_q       <= out_col_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        g_d     = g_q;
        f_d     = f_q;
        k_d     = k_q;
        full_d  = full_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    r_d     = ROW_W'(1);
                    g_d     = '0;
                    f_d     = '0;
                    full_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (fetch_ack && fetch_req_q) begin
                    if (e_q == 3'd5) begin
                        k_d     = '0;
                        f_d     = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        f_d = f_q + 3'd1;
                    end
                end
            end
            S_COMPUTE: state_d = S_WAIT;
            S_WAIT: begin
                if (compute_done) begin
                    if (k_q != 2'd3) begin
                        k_d     = k_q + 2'd1;
                        state_d = S_COMPUTE;
                    end else if (g_q < G_LAST) begin
                        state_d = S_SHIFT;
                    end else if (r_q < R_LAST) begin
                        r_d     = r_q + ROW_W'(1);
                        g_d     = '0;
                        f_d     = '0;
                        full_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                g_d     = g_q + GRP_W'(1);
                f_d     = '0;
                full_d  = 1'b0;
                state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state; registered above
    always_comb begin
        e_d             = full_d ? f_d : f_d + 3'd3;
        fetch_req_d     = 1'b0;
        fetch_row_d     = '0;
        fetch_grp_d     = '0;
        fill_line_d     = '0;
        fill_half_d     = 1'b0;
        comp_pos_d      = '0;
        out_row_d       = '0;
        out_col_d       = '0;
        shift_win_d     = (state_d == S_SHIFT);
        compute_start_d = (state_d == S_COMPUTE);
        frame_done_d    = (state_d == S_DONE);
        busy_d          = (state_d != S_IDLE);
        if (state_d == S_FETCH) begin
            fetch_req_d = 1'b1;
            fill_half_d = (e_d >= 3'd3);
            fill_line_d = fill_half_d ? 2'(e_d - 3'd3) : e_d[1:0];
            fetch_row_d = r_d - ROW_W'(1) + ROW_W'(fill_line_d);
            fetch_grp_d = g_d + GRP_W'(fill_half_d);
        end
        // Position stays valid through WAIT so the kernel may sample it late
        if (state_d == S_COMPUTE || state_d == S_WAIT) begin
            comp_pos_d = k_d;
            out_row_d  = r_d;
            out_col_d  = COL_W'({g_d, 2'b00}) + COL_W'(k_d) + COL_W'(1);
        end
    end

    assign fetch_req     = fetch_req_q;
    assign fetch_row     = fetch_row_q;
    assign fetch_grp     = fetch_grp_q;
    assign fill_line     = fill_line_q;
    assign fill_half     = fill_half_q;
    assign shift_win     = shift_win_q;
    assign compute_start = compute_start_q;
    assign comp_pos      = comp_pos_q;
    assign out_row       = out_row_q;
    assign out_col       = out_col_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_sobel_window_scheduler.sv
// Bench for sobel_window_scheduler: a 16x4 instance (A) for the main scenarios and
// an 8x3 instance (B) for the minimal frame. Transfers are encoded as
// row*1000 + grp*100 + line*10 + half, compute positions as row*100 + col.
module tb_sobel_window_scheduler;

    localparam int A_W = 16;
    localparam int A_H = 4;
    localparam int A_G = A_W / 4;

    logic clk;
    logic n_rst;

    // instance A (16x4)
    logic       start_a, fetch_ack_a, compute_done_a;
    logic       fetch_req_a, fill_half_a, shift_win_a, compute_start_a, busy_a, frame_done_a;
    logic [1:0] fetch_row_a, fetch_grp_a, fill_line_a, comp_pos_a, out_row_a;
    logic [3:0] out_col_a;
    logic [19:0] outs_a;

    // instance B (8x3)
    logic       start_b, fetch_ack_b, compute_done_b;
    logic       fetch_req_b, fill_half_b, shift_win_b, compute_start_b, busy_b, frame_done_b;
    logic [1:0] fetch_row_b, fill_line_b, comp_pos_b, out_row_b;
    logic [0:0] fetch_grp_b;
    logic [2:0] out_col_b;
    logic [17:0] outs_b;

    int checks = 0;
    int fails  = 0;

    sobel_window_scheduler #(.IMG_W(A_W), .IMG_H(A_H)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a),
        .fetch_req(fetch_req_a), .fetch_row(fetch_row_a), .fetch_grp(fetch_grp_a),
        .fill_line(fill_line_a), .fill_half(fill_half_a), .fetch_ack(fetch_ack_a),
        .shift_win(shift_win_a), .compute_start(compute_start_a), .comp_pos(comp_pos_a),
        .out_row(out_row_a), .out_col(out_col_a), .compute_done(compute_done_a),
        .busy(busy_a), .frame_done(frame_done_a)
    );

    sobel_window_scheduler #(.IMG_W(8), .IMG_H(3)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b),
        .fetch_req(fetch_req_b), .fetch_row(fetch_row_b), .fetch_grp(fetch_grp_b),
        .fill_line(fill_line_b), .fill_half(fill_half_b), .fetch_ack(fetch_ack_b),
        .shift_win(shift_win_b), .compute_start(compute_start_b), .comp_pos(comp_pos_b),
        .out_row(out_row_b), .out_col(out_col_b), .compute_done(compute_done_b),
        .busy(busy_b), .frame_done(frame_done_b)
    );

    assign outs_a = {fetch_req_a, fetch_row_a, fetch_grp_a, fill_line_a, fill_half_a, shift_win_a,
                     compute_start_a, comp_pos_a, out_row_a, out_col_a, busy_a, frame_done_a};
    assign outs_b = {fetch_req_b, fetch_row_b, fetch_grp_b, fill_line_b, fill_half_b, shift_win_b,
                     compute_start_b, comp_pos_b, out_row_b, out_col_b, busy_b, frame_done_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame on A with randomised ack/done delays, checking every transfer,
    // every compute position, address stability and the handshake latencies.
    // With abort set it returns as soon as the second window's fetch is visible.
    task automatic run_a(input string tag, input int ack_max, input int done_max,
                         input bit spur, input bit abort,
                         output int nf, output int nc, output int ns, output int nd,
                         output bit fin);
        int exp_f[$];
        int exp_c[$];
        int pend, ack_d, done_wait, cur, obs, ex;
        bit p_last_ack, p_shift, p_done, p_fd, n_last_ack, n_done;
        logic got;
        nf = 0; nc = 0; ns = 0; nd = 0; fin = 1'b0;
        pend = 0; ack_d = 0; done_wait = 0; cur = 0;
        p_last_ack = 0; p_shift = 0; p_done = 0; p_fd = 0;
        for (int r = 1; r <= A_H - 2; r++) begin
            for (int w = 0; w <= A_G - 2; w++) begin
                if (w == 0) begin
                    for (int h = 0; h < 2; h++)
                        for (int l = 0; l < 3; l++)
                            exp_f.push_back((r - 1 + l) * 1000 + h * 100 + l * 10 + h);
                end else begin
                    for (int l = 0; l < 3; l++)
                        exp_f.push_back((r - 1 + l) * 1000 + (w + 1) * 100 + l * 10 + 1);
                end
                for (int k = 0; k < 4; k++) exp_c.push_back(r * 100 + 4 * w + k + 1);
            end
        end

        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        checks++;
        if ({busy_a, fetch_req_a} !== 2'b11) begin
            fails++;
            $display("FAIL %s_start_latency got=%b want=11", tag, {busy_a, fetch_req_a});
        end

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            fetch_ack_a = 1'b0; compute_done_a = 1'b0; start_a = 1'b0;
            if (abort && ns >= 1 && fetch_req_a) return;
            if (p_fd) begin
                checks++;
                if (busy_a !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_busy_after_done got=%b want=0", tag, busy_a);
                end
                fin = 1'b1;
            end else begin
                if (p_last_ack) begin
                    checks++;
                    if (compute_start_a !== 1'b1) begin
                        fails++;
                        $display("FAIL %s_ack_to_compute got=%b want=1", tag, compute_start_a);
                    end
                end
                if (p_shift) begin
                    checks++;
                    if (fetch_req_a !== 1'b1) begin
                        fails++;
                        $display("FAIL %s_shift_to_fetch got=%b want=1", tag, fetch_req_a);
                    end
                end
                if (p_done) begin
                    if (nc == exp_c.size())          got = frame_done_a;
                    else if (nc % 4 != 0)            got = compute_start_a;
                    else if ((nc / 4) % (A_G - 1) != 0) got = shift_win_a;
                    else                             got = fetch_req_a;
                    checks++;
                    if (got !== 1'b1) begin
                        fails++;
                        $display("FAIL %s_done_followup after %0d computes got=%b want=1", tag, nc, got);
                    end
                end
                n_last_ack = 0; n_done = 0;
                if (frame_done_a) begin
                    nd++;
                    if (spur) start_a = 1'b1;
                end
                if (shift_win_a) ns++;
                if (compute_start_a) begin
                    obs = int'(out_row_a) * 100 + int'(out_col_a);
                    ex  = (nc < exp_c.size()) ? exp_c[nc] : -1;
                    checks++;
                    if (obs !== ex) begin
                        fails++;
                        $display("FAIL %s_compute%0d got=%0d want=%0d", tag, nc, obs, ex);
                    end
                    checks++;
                    if (ex >= 0 && int'(comp_pos_a) !== ((ex % 100) - 1) % 4) begin
                        fails++;
                        $display("FAIL %s_comp_pos%0d got=%0d want=%0d", tag, nc, comp_pos_a, ((ex % 100) - 1) % 4);
                    end
                    nc++;
                    done_wait = 1 + int'($urandom_range(0, done_max));
                end else if (done_wait > 0) begin
                    done_wait--;
                    if (done_wait == 0) begin
                        compute_done_a = 1'b1;
                        n_done = 1;
                    end
                end
                if (fetch_req_a) begin
                    obs = int'(fetch_row_a) * 1000 + int'(fetch_grp_a) * 100 +
                          int'(fill_line_a) * 10 + int'(fill_half_a);
                    if (pend == 0) begin
                        pend = 1; cur = obs;
                        ack_d = int'($urandom_range(0, ack_max));
                    end else begin
                        checks++;
                        if (obs !== cur) begin
                            fails++;
                            $display("FAIL %s_addr_stable got=%0d want=%0d", tag, obs, cur);
                        end
                    end
                    if (ack_d == 0) begin
                        fetch_ack_a = 1'b1;
                        pend = 0;
                        ex = (nf < exp_f.size()) ? exp_f[nf] : -1;
                        checks++;
                        if (obs !== ex) begin
                            fails++;
                            $display("FAIL %s_fetch%0d got=%0d want=%0d", tag, nf, obs, ex);
                        end
                        nf++;
                        n_last_ack = (fill_line_a == 2'd2 && fill_half_a == 1'b1);
                    end else begin
                        ack_d--;
                    end
                    if (spur) begin
                        compute_done_a = 1'b1;
                        start_a = 1'b1;
                    end
                end else if (spur && (cyc % 2 == 1)) begin
                    fetch_ack_a = 1'b1;
                end
                p_last_ack = n_last_ack; p_shift = shift_win_a; p_done = n_done; p_fd = frame_done_a;
            end
            if (!fin) @(negedge clk);
        end
        fetch_ack_a = 1'b0; compute_done_a = 1'b0; start_a = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (outs_a !== 20'd0) begin
            fails++;
            $display("FAIL reset_outs_a got=%h want=0", outs_a);
        end
        checks++;
        if (outs_b !== 18'd0) begin
            fails++;
            $display("FAIL reset_outs_b got=%h want=0", outs_b);
        end
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; fetch_ack_a = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_pre_busy got=%b want=1", busy_a);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (outs_a !== 20'd0) begin
            fails++;
            $display("FAIL reset_async_outs got=%h want=0", outs_a);
        end
        fetch_ack_a = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_a !== 20'd0) begin
            fails++;
            $display("FAIL reset_stays_idle got=%h want=0", outs_a);
        end
    endtask

    task automatic test_minimal();
        int exp_f[6] = '{0, 1010, 2020, 101, 1111, 2121};
        int nf = 0, nc = 0, ns = 0, nd = 0, obs;
        bit fin = 0, p_cs = 0, p_fd = 0;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            fetch_ack_b = fetch_req_b;
            compute_done_b = p_cs;
            if (p_fd) begin
                checks++;
                if (busy_b !== 1'b0) begin
                    fails++;
                    $display("FAIL min_busy_after_done got=%b want=0", busy_b);
                end
                fin = 1;
            end else begin
                if (fetch_req_b) begin
                    obs = int'(fetch_row_b) * 1000 + int'(fetch_grp_b) * 100 +
                          int'(fill_line_b) * 10 + int'(fill_half_b);
                    checks++;
                    if (nf >= 6 || obs !== exp_f[nf % 6]) begin
                        fails++;
                        $display("FAIL min_fetch%0d got=%0d want=%0d", nf, obs, exp_f[nf % 6]);
                    end
                    nf++;
                end
                if (compute_start_b) begin
                    obs = int'(out_row_b) * 100 + int'(out_col_b);
                    checks++;
                    if (obs !== 101 + nc) begin
                        fails++;
                        $display("FAIL min_compute%0d got=%0d want=%0d", nc, obs, 101 + nc);
                    end
                    nc++;
                end
                if (shift_win_b) ns++;
                if (frame_done_b) nd++;
                p_cs = compute_start_b;
                p_fd = frame_done_b;
                @(negedge clk);
            end
        end
        fetch_ack_b = 1'b0; compute_done_b = 1'b0;
        checks++;
        if ({fin, nf, nc, ns, nd} !== {1'b1, 32'd6, 32'd4, 32'd0, 32'd1}) begin
            fails++;
            $display("FAIL min_counts got fin=%0d f=%0d c=%0d s=%0d d=%0d want fin=1 f=6 c=4 s=0 d=1",
                     fin, nf, nc, ns, nd);
        end
    endtask

    task automatic test_full_frame();
        int nf, nc, ns, nd; bit fin;
        run_a("full", 0, 0, 0, 0, nf, nc, ns, nd, fin);
        checks++;
        if ({fin, nf, nc, ns, nd} !== {1'b1, 32'd24, 32'd24, 32'd4, 32'd1}) begin
            fails++;
            $display("FAIL full_counts got fin=%0d f=%0d c=%0d s=%0d d=%0d want fin=1 f=24 c=24 s=4 d=1",
                     fin, nf, nc, ns, nd);
        end
    endtask

    task automatic test_backpressure();
        int nf, nc, ns, nd; bit fin;
        run_a("bp", 5, 7, 0, 0, nf, nc, ns, nd, fin);
        checks++;
        if ({fin, nf, nc, ns, nd} !== {1'b1, 32'd24, 32'd24, 32'd4, 32'd1}) begin
            fails++;
            $display("FAIL bp_counts got fin=%0d f=%0d c=%0d s=%0d d=%0d want fin=1 f=24 c=24 s=4 d=1",
                     fin, nf, nc, ns, nd);
        end
    endtask

    task automatic test_spurious();
        int nf, nc, ns, nd; bit fin;
        run_a("spur", 3, 3, 1, 0, nf, nc, ns, nd, fin);
        checks++;
        if ({fin, nf, nc, ns, nd} !== {1'b1, 32'd24, 32'd24, 32'd4, 32'd1}) begin
            fails++;
            $display("FAIL spur_counts got fin=%0d f=%0d c=%0d s=%0d d=%0d want fin=1 f=24 c=24 s=4 d=1",
                     fin, nf, nc, ns, nd);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin
            fails++;
            $display("FAIL spur_start_in_done got busy=%b want=0", busy_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nf, nc, ns, nd; bit fin;
        run_a("rmf_abort", 2, 0, 0, 1, nf, nc, ns, nd, fin);
        fetch_ack_a = 1'b0; compute_done_a = 1'b0; start_a = 1'b0;
        checks++;
        if (fetch_req_a !== 1'b1 || ns !== 1) begin
            fails++;
            $display("FAIL rmf_position got req=%b shifts=%0d want req=1 shifts=1", fetch_req_a, ns);
        end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if (outs_a !== 20'd0) begin
            fails++;
            $display("FAIL rmf_reset_outs got=%h want=0", outs_a);
        end
        @(negedge clk); n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_a !== 20'd0) begin
            fails++;
            $display("FAIL rmf_no_frame_done got=%h want=0", outs_a);
        end
        run_a("rmf_restart", 0, 0, 0, 0, nf, nc, ns, nd, fin);
        checks++;
        if ({fin, nf, nc, ns, nd} !== {1'b1, 32'd24, 32'd24, 32'd4, 32'd1}) begin
            fails++;
            $display("FAIL rmf_counts got fin=%0d f=%0d c=%0d s=%0d d=%0d want fin=1 f=24 c=24 s=4 d=1",
                     fin, nf, nc, ns, nd);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start_a = 1'b0; fetch_ack_a = 1'b0; compute_done_a = 1'b0;
        start_b = 1'b0; fetch_ack_b = 1'b0; compute_done_b = 1'b0;
        #12;
        test_reset();
        test_minimal();
        test_full_frame();
        test_backpressure();
        test_spurious();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
